// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program-memory boot loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 2;

  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - receives a framed byte image, writes it to program memory and releases the CPU
// Frame: LEN(2, MSB first), N words (MSB first), CHK = XOR of all preceding frame bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int CW = ADDR_W + 1;

  loader_state_t     state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        xor_q, xor_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              accept;
  logic [15:0]       len_full;
  logic [31:0]       len_ext;

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept   = in_valid && in_ready;
  // hi_q holds either the LEN high byte or the data high byte, depending on state
  assign len_full = {hi_q, in_byte};
  assign len_ext  = {16'd0, len_full};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    xor_d   = xor_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      if (state_q != S_CHK) begin
        xor_d = xor_q ^ in_byte;
      end
      case (state_q)
        S_LEN_HI: begin
          hi_d    = in_byte;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          n_d = CW'(len_full);
          if (len_ext > max_words(ADDR_W)) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = in_byte;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = DATA_W'({hi_q, in_byte});
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == n_q - CW'(1)) ? S_CHK : S_DATA_HI;
        end
        S_CHK: begin
          state_d = (in_byte == xor_q) ? S_DONE : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      hi_q    <= '0;
      xor_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      xor_q   <= xor_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  // System reset is folded in so the CPU is held even before the loader's own reset lands
  assign cpu_reset = reset || (state_q != S_DONE);

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot loader that fills the CPU's program memory from a byte stream before the CPU runs. The CPU only reads program memory. This block is the writer on the other side of that memory: it receives a framed image, writes each 16-bit word to consecutive addresses and checks a checksum. It holds the CPU in reset until the image is accepted. It sits between an external byte source and the program-memory write port, and drives the CPU's `reset` input.

## Interface
Parameters:
- `ADDR_W`, 10, program-memory address width; maximum image size is 2^ADDR_W words.
- `DATA_W`, 16, instruction word width; fixed at 2 bytes per word.

Ports:
- `clk`, in, 1, single clock.
- `reset`, in, 1, synchronous, active-high.
- `in_valid`, in, 1, `in_byte` is valid this cycle.
- `in_byte`, in, 8, stream byte.
- `in_ready`, out, 1, loader accepts a byte this cycle.
- `mem_we`, out, 1, program-memory write strobe.
- `mem_waddr`, out, ADDR_W, write address.
- `mem_wdata`, out, DATA_W, write data.
- `cpu_reset`, out, 1, drives the CPU `reset`; 1 holds the CPU in reset.
- `done`, out, 1, image accepted and CPU released.
- `err`, out, 1, image rejected.

## Operation
- A byte is accepted in any cycle with `in_valid && in_ready`.
- Frame format, multi-byte fields high byte first:
  - LEN, 2 bytes: word count N.
  - N words, 2 bytes each.
  - CHK, 1 byte: XOR of all preceding frame bytes.
- FSM states: `S_LEN_HI`, `S_LEN_LO`, `S_DATA_HI`, `S_DATA_LO`, `S_CHK`, `S_DONE`, `S_ERR`.
- Transitions (each on byte accept unless noted):
  - `S_LEN_HI` → `S_LEN_LO`.
  - `S_LEN_LO`:
    - N > 2^ADDR_W → `S_ERR`.
    - N == 0 → `S_CHK`.
    - else → `S_DATA_HI`.
  - `S_DATA_HI` → `S_DATA_LO`; the high byte is latched.
  - `S_DATA_LO`: the word write is issued; → `S_CHK` if this was word N-1, else → `S_DATA_HI`.
  - `S_CHK`: → `S_DONE` if the byte equals the running XOR, else → `S_ERR`.
  - `S_DONE` and `S_ERR` are terminal; only `reset` leaves them.
- Counters and arithmetic:
  - Running XOR is 8 bits, cleared on reset, updated with every accepted byte except CHK.
  - Word counter is ADDR_W+1 bits, starts at 0, increments on each word write.
  - `mem_waddr` is the counter's low ADDR_W bits; words land at addresses 0..N-1.
  - N = 2^ADDR_W is legal: the last write goes to address 2^ADDR_W − 1, with no wrap.
- `in_ready` is 1 in all receive states and 0 in `S_DONE` and `S_ERR`. Bytes arriving while `in_ready` is 0 are ignored.
- Reset values: `in_ready`=1, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_reset`=1, `done`=0, `err`=0, state `S_LEN_HI`.
- `cpu_reset`=1 in every state except `S_DONE`.
- In `S_ERR`:
  - `err`=1 and the CPU stays in reset.
  - Words already written remain in memory; no rollback.
- Reset mid-frame:
  - Aborts the frame and returns to `S_LEN_HI` with counter and XOR cleared.
  - No `mem_we` is issued in the cycle after reset.

## Timing
- Word write:
  - `mem_we`, `mem_waddr` and `mem_wdata` are registered outputs.
  - `mem_we` is high for exactly the one cycle after the `S_DATA_LO` accept.
  - Address and data are valid in that same cycle.
- Back-to-back bytes (`in_valid` held high) give one word write every 2 cycles; `in_valid` gaps only stretch the spacing.
- `done`=1 and `cpu_reset`=0 take effect the cycle after the CHK byte is accepted.
- `err`=1 takes effect the cycle after the offending LEN_LO or CHK accept.
- `in_ready` drops in the same cycle that `done` or `err` rises.
- Zero-wait acceptance: the FSM never stalls the input.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum `loader_state_t`.
  - `BYTES_PER_WORD` = 2.
  - function `max_words(ADDR_W)`.
- Single module; no sub-module is needed, since the checksum and counter are one register each.
- At top level, `cpu_reset` is ORed with the system `reset` before it reaches the CPU.

## Test plan
- Nominal load: stream `00 02 12 34 AB CD 42`.
  - Writes (0, 0x1234) and (1, 0xABCD), each as a 1-cycle `mem_we`.
  - `done`=1 and `cpu_reset`=0 the cycle after 0x42 is accepted.
- Empty image: stream `00 00 00`.
  - No `mem_we` pulses; `done`=1 after the third byte.
- Oversize length with ADDR_W=10: stream `04 01`.
  - `err`=1 the next cycle, `in_ready`=0, `cpu_reset` stays 1, no writes.
- Bad checksum: stream `00 02 12 34 AB CD 43`.
  - Both writes occur, then `err`=1, `done`=0, `cpu_reset`=1.
- Reset mid-frame: `00 02 12` followed by a 1-cycle `reset`, then the nominal stream.
  - First write is at address 0 with data 0x1234; `done`=1 at the end.
- Throttled input: nominal stream with random 0–3 cycle `in_valid` gaps.
  - Same writes and same final state as the nominal load; no duplicate `mem_we`.
